// File: rtl/updown_pkg.sv
// Shared encodings, defaults and sizing helpers for the up/down direction controller.
// Optional macro UPDOWN_CHG_CNT_EN (consumed in updown_dir_ctrl) adds the chg_cnt port.
package updown_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_DEB_CYCLES = 4;

    // Counter must be able to hold DEB_CYCLES itself.
    function automatic int deb_cnt_w(input int deb_cycles);
        return $clog2(deb_cycles + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability counter and rising-edge press detector for a raw button.
// btn_db follows btn_in 2 + DEB_CYCLES cycles after a clean edge; press is one cycle wide.
module btn_debounce
    import updown_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_db,
    output logic press
);

    localparam int            CW       = deb_cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          btn_s;
    logic          db_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= 1'b0;
            btn_s  <= 1'b0;
            btn_db <= 1'b0;
            db_q   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= btn_in;
            btn_s <= sync1;
            db_q  <= btn_db;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (btn_s == btn_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                btn_db <= btn_s;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = btn_db & ~db_q;

endmodule

// File: rtl/updown_dir_ctrl.sv
// Direction controller for the sync_updown counter: button toggle plus optional auto-bounce.
// Optional macro UPDOWN_CHG_CNT_EN adds chg_cnt, a saturating count of direction changes.
module updown_dir_ctrl
    import updown_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int MIN_VAL    = 0,
    parameter int MAX_VAL    = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    input  logic             mode,
    input  logic [WIDTH-1:0] count_in,
    output logic             up_down,
    output logic             dir_change,
    output logic             btn_db
`ifdef UPDOWN_CHG_CNT_EN
    ,
    output logic [7:0]       chg_cnt
`endif
);

    // Reverse one value early: the counter samples up_down on the same edge we switch.
    localparam logic [WIDTH-1:0] TRIG_HI = WIDTH'(MAX_VAL - 1);
    localparam logic [WIDTH-1:0] TRIG_LO = WIDTH'(MIN_VAL + 1);

    logic press;
    logic auto_hit;
    logic toggle;
    dir_t state;
    dir_t state_nxt;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk   (clk),
        .rst   (rst),
        .btn_in(btn_in),
        .btn_db(btn_db),
        .press (press)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= DIR_DOWN;
            dir_change <= 1'b0;
        end else begin
            state      <= state_nxt;
            dir_change <= toggle;
        end
    end

    // Press and auto condition are OR-ed so a coincidence yields a single toggle.
    always_comb begin
        auto_hit  = 1'b0;
        state_nxt = state;
        if (mode) begin
            case (state)
                DIR_UP:   auto_hit = (count_in == TRIG_HI);
                DIR_DOWN: auto_hit = (count_in == TRIG_LO);
                default:  auto_hit = 1'b0;
            endcase
        end
        toggle = press | auto_hit;
        if (toggle) begin
            state_nxt = (state == DIR_UP) ? DIR_DOWN : DIR_UP;
        end
    end

    assign up_down = (state == DIR_UP);

`ifdef UPDOWN_CHG_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chg_cnt <= 8'd0;
        end else if (dir_change && (chg_cnt != 8'hFF)) begin
            chg_cnt <= chg_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_updown_dir_ctrl.sv
// Bench for updown_dir_ctrl: directed scenarios plus random stimulus against a behavioural model.
// The model tracks button samples as a history window and the direction as a plain bit.
module tb_updown_dir_ctrl;

    localparam int WIDTH = 4;
    localparam int DEB   = 4;
    localparam int MINV  = 0;
    localparam int MAXV  = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             btn_in;
    logic             mode;
    logic [WIDTH-1:0] count_in;
    logic             up_down;
    logic             dir_change;
    logic             btn_db;
`ifdef UPDOWN_CHG_CNT_EN
    logic [7:0]       chg_cnt;
`endif

    updown_dir_ctrl #(
        .WIDTH(WIDTH), .DEB_CYCLES(DEB), .MIN_VAL(MINV), .MAX_VAL(MAXV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .mode      (mode),
        .count_in  (count_in),
        .up_down   (up_down),
        .dir_change(dir_change),
        .btn_db    (btn_db)
`ifdef UPDOWN_CHG_CNT_EN
        ,
        .chg_cnt   (chg_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks;
    int errors;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural model state
    logic m_samp[$];
    logic m_db;
    logic m_press_pend;
    logic m_dir;
    logic m_chg;
    int   m_cc;
    bit   closed;
    int   cnt;

    task automatic model_reset();
        m_samp = {};
        for (int i = 0; i < DEB + 2; i++) m_samp.push_front(1'b0);
        m_db         = 1'b0;
        m_press_pend = 1'b0;
        m_dir        = 1'b0;
        m_chg        = 1'b0;
        m_cc         = 0;
    endtask

    // Called right at a rising edge; uses the input values held through the cycle.
    task automatic model_edge();
        bit auto_hit;
        bit toggle;
        bit flip;
        if (!rst) begin
            model_reset();
            return;
        end
        if (m_chg && m_cc < 255) m_cc++;
        auto_hit = mode && ((m_dir && count_in == MAXV - 1) || (!m_dir && count_in == MINV + 1));
        toggle   = m_press_pend || auto_hit;
        if (closed) cnt = m_dir ? cnt + 1 : cnt - 1;
        if (toggle) m_dir = !m_dir;
        m_chg = toggle;
        // The debouncer sees the button as sampled two edges ago; flip once DEB such samples disagree.
        m_samp.push_front(btn_in);
        void'(m_samp.pop_back());
        flip = 1'b1;
        for (int i = 2; i < DEB + 2; i++) if (m_samp[i] == m_db) flip = 1'b0;
        m_press_pend = 1'b0;
        if (flip) begin
            m_db         = !m_db;
            m_press_pend = m_db;
        end
    endtask

    task automatic compare_all();
        check("btn_db", btn_db, m_db);
        check("up_down", up_down, m_dir);
        check("dir_change", dir_change, m_chg);
`ifdef UPDOWN_CHG_CNT_EN
        check("chg_cnt", chg_cnt, m_cc);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (closed) count_in = cnt[WIDTH-1:0];
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        step();
        rst = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int pulses;
    int db_lat;
    int ud_lat;
    int cmin;
    int cmax;
    int out_rng;
    int bad_pulse;
    int run_left;

    initial begin
        checks = 0;
        errors = 0;
        closed = 0;
        cnt    = 0;
        rst      = 1'b0;
        btn_in   = 1'b1;
        mode     = 1'b1;
        count_in = '0;
        model_reset();

        // Reset held with button pressed and auto mode on
        repeat (3) begin
            @(negedge clk);
            compare_all();
        end
        rst    = 1'b1;
        db_lat = -1;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (btn_db && db_lat < 0) db_lat = n;
        end
        check("rst_release_db_latency", db_lat, 6);

        // Clean press, manual mode
        btn_in = 1'b0;
        mode   = 1'b0;
        do_reset();
        btn_in = 1'b1;
        pulses = 0; db_lat = -1; ud_lat = -1;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (dir_change) pulses++;
            if (btn_db && db_lat < 0) db_lat = n;
            if (up_down && ud_lat < 0) ud_lat = n;
        end
        check("press_db_latency", db_lat, 6);
        check("press_up_down_latency", ud_lat, 7);
        check("press_pulses", pulses, 1);
        btn_in = 1'b0;
        pulses = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (dir_change) pulses++;
        end
        check("release_pulses", pulses, 0);
        check("release_up_down", up_down, 1);
        btn_in = 1'b1;
        repeat (12) step();
        btn_in = 1'b0;
        repeat (10) step();
        check("second_press_up_down", up_down, 0);

        // Glitch of two cycles
        btn_in = 1'b1;
        repeat (2) step();
        btn_in = 1'b0;
        pulses = 0; db_lat = 0;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (dir_change) pulses++;
            if (btn_db) db_lat++;
        end
        check("glitch_pulses", pulses, 0);
        check("glitch_db_high_cycles", db_lat, 0);
        check("glitch_up_down", up_down, 0);

        // Closed-loop auto-bounce
        mode     = 1'b1;
        count_in = '0;
        do_reset();
        btn_in = 1'b1;
        for (int n = 0; n < 12 && !m_dir; n++) step();
        btn_in = 1'b0;
        cnt = 0; closed = 1; cmin = 99; cmax = -99; out_rng = 0; bad_pulse = 0; pulses = 0;
        for (int n = 1; n <= 70; n++) begin
            step();
            if (cnt < cmin) cmin = cnt;
            if (cnt > cmax) cmax = cnt;
            if (cnt < MINV || cnt > MAXV) out_rng++;
            if (dir_change) begin
                pulses++;
                if (cnt != MAXV && cnt != MINV) bad_pulse++;
            end
        end
        closed = 0;
        check("bounce_min", cmin, MINV);
        check("bounce_max", cmax, MAXV);
        check("bounce_out_of_range", out_rng, 0);
        check("bounce_pulse_position", bad_pulse, 0);
        check("bounce_pulses", pulses, 4);

        // Press event coinciding with the auto trigger
        count_in = '0;
        do_reset();
        btn_in = 1'b1;
        repeat (10) step();
        btn_in = 1'b0;
        repeat (10) step();
        check("simul_pre_up_down", up_down, 1);
        btn_in = 1'b1;
        repeat (6) step();
        count_in = 4'(MAXV - 1);
        pulses = 0;
        step();
        if (dir_change) pulses++;
        count_in = '0;
        for (int n = 0; n < 4; n++) begin
            step();
            if (dir_change) pulses++;
        end
        btn_in = 1'b0;
        check("simul_pulses", pulses, 1);
        check("simul_up_down", up_down, 0);
        repeat (8) step();

        // Reset in the middle of a debounce while going up
        mode = 1'b0;
        btn_in = 1'b1;
        repeat (10) step();
        btn_in = 1'b0;
        repeat (4) step();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("midrst_up_down", up_down, 0);
        check("midrst_btn_db", btn_db, 0);
        check("midrst_dir_change", dir_change, 0);
`ifdef UPDOWN_CHG_CNT_EN
        check("midrst_chg_cnt", chg_cnt, 0);
`endif
        repeat (2) step();
        rst = 1'b1;
        btn_in = 1'b1;
        repeat (10) step();
        btn_in = 1'b0;
        check("midrst_repress_up_down", up_down, 1);

        // Toggle every cycle through the auto rule (drives chg_cnt into saturation)
        mode = 1'b1;
        repeat (6) step();
        for (int n = 0; n < 300; n++) begin
            count_in = m_dir ? 4'(MAXV - 1) : 4'(MINV + 1);
            step();
        end
`ifdef UPDOWN_CHG_CNT_EN
        check("chg_cnt_saturated", chg_cnt, 255);
`endif

        // Random stimulus
        run_left = 0;
        for (int n = 0; n < 1500; n++) begin
            if (run_left == 0) begin
                btn_in   = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, 8);
            end
            run_left--;
            if ($urandom_range(0, 31) == 0) mode = !mode;
            case ($urandom_range(0, 3))
                0:       count_in = 4'(MINV + 1);
                1:       count_in = 4'(MAXV - 1);
                default: count_in = 4'($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 199) == 0) do_reset();
            else step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
